weight_spi_loader: RTL and testbench

SPI slave that receives weight frames from an external host and turns them into single-byte writes on the weight register bank's load port. It drives the bank's address, data and active-low load strobe.
- It is the writer for that port; the CNN datapath reads the bank independently.
- It also reports frame status (busy, done, error, word count) to the top-level controller.

---
 rtl/weight_loader_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/weight_spi_loader.sv | 192 +++++++++++++++++++
 tb/tb_weight_spi_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the SPI weight loader.
package weight_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    DATA,
    DISCARD
  } loader_state_e;

  localparam logic [7:0]  CMD_WRITE_DEFAULT = 8'h02;
  localparam int unsigned SYNC_STAGES       = 2;
  localparam int unsigned SPI_BYTE_BITS     = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser for an asynchronous SPI line with single-clock rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Chain resets low so a line already low at reset release never yields a fall pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/weight_spi_loader.sv
// SPI slave that turns host weight frames into single-byte writes on the weight bank load port.
module weight_spi_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned NUM_WEIGHTS   = 10422,
  parameter logic [7:0]  CMD_WRITE     = CMD_WRITE_DEFAULT
) (
  input  logic                     Loader_Clock_In_Data,
  input  logic                     Loader_Reset_InHigh,
  input  logic                     Loader_SCLK_In,
  input  logic                     Loader_CSn_In,
  input  logic                     Loader_MOSI_In,
  output logic                     Loader_MISO_Out,
  output logic [ADDRESS_WIDTH-1:0] Loader_Addr_Out_DataBUS,
  output logic [DATAWIDTH_BUS-1:0] Loader_Data_Out_DataBUS,
  output logic                     Loader_Load_OutLow,
  output logic                     Loader_Busy_Out,
  output logic                     Loader_Done_Out,
  output logic                     Loader_Error_Out,
  output logic [ADDRESS_WIDTH-1:0] Loader_WordCount_Out
);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .i_clk   (Loader_Clock_In_Data),
    .i_rst   (Loader_Reset_InHigh),
    .i_async (Loader_SCLK_In),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn_sync (
    .i_clk   (Loader_Clock_In_Data),
    .i_rst   (Loader_Reset_InHigh),
    .i_async (Loader_CSn_In),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  logic [SYNC_STAGES-1:0]   r_mosi_sync;
  logic [2:0]               r_bitcnt;
  logic [7:0]               r_shift;
  logic [7:0]               r_addr_hi;
  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic [ADDRESS_WIDTH-1:0] r_addr_out;
  logic [DATAWIDTH_BUS-1:0] r_data_out;
  logic [ADDRESS_WIDTH-1:0] r_wc;
  logic [7:0]               r_miso_sr;
  logic                     r_miso_pend;
  logic                     r_load_n, r_inc_pend, r_busy, r_done, r_error;
  loader_state_e            r_state, w_next;

  logic [7:0]               w_byte;
  logic                     w_byte_done;
  logic [15:0]              w_addr_full;
  logic [ADDRESS_WIDTH-1:0] w_addr_trunc;
  logic                     w_start_ok, w_ptr_ok;
  logic                     w_set_err, w_ld_hi, w_ld_addr, w_write;

  assign w_byte       = {r_shift[6:0], r_mosi_sync[SYNC_STAGES-1]};
  assign w_byte_done  = w_sclk_rise && (r_bitcnt == 3'(SPI_BYTE_BITS - 1));
  assign w_addr_full  = {r_addr_hi, w_byte};
  assign w_addr_trunc = w_addr_full[ADDRESS_WIDTH-1:0];
  assign w_start_ok   = 32'(w_addr_trunc) < NUM_WEIGHTS;
  assign w_ptr_ok     = 32'(r_ptr) < NUM_WEIGHTS;

  always_ff @(posedge Loader_Clock_In_Data) begin
    if (Loader_Reset_InHigh) r_state <= IDLE;
    else                     r_state <= w_next;
  end

  // A CSn fall outside IDLE restarts the frame directly.
  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    w_ld_hi   = 1'b0;
    w_ld_addr = 1'b0;
    w_write   = 1'b0;
    if (w_cs_fall) begin
      w_next = CMD;
    end else if (w_cs_rise) begin
      w_next = IDLE;
    end else if (w_byte_done) begin
      case (r_state)
        CMD: begin
          if (w_byte == CMD_WRITE) w_next = ADDR_HI;
          else begin
            w_set_err = 1'b1;
            w_next    = DISCARD;
          end
        end
        ADDR_HI: begin
          w_ld_hi = 1'b1;
          w_next  = ADDR_LO;
        end
        ADDR_LO: begin
          if (w_start_ok) begin
            w_ld_addr = 1'b1;
            w_next    = DATA;
          end else begin
            w_set_err = 1'b1;
            w_next    = DISCARD;
          end
        end
        DATA: begin
          if (w_ptr_ok) w_write = 1'b1;
          else begin
            w_set_err = 1'b1;
            w_next    = DISCARD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Loader_Clock_In_Data) begin
    if (Loader_Reset_InHigh) begin
      r_mosi_sync <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_addr_hi   <= '0;
      r_ptr       <= '0;
      r_addr_out  <= '0;
      r_data_out  <= '0;
      r_wc        <= '0;
      r_miso_sr   <= '0;
      r_miso_pend <= 1'b0;
      r_load_n    <= 1'b1;
      r_inc_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], Loader_MOSI_In};
      r_load_n    <= ~w_write;
      r_inc_pend  <= w_write;
      r_done      <= (w_cs_rise || w_cs_fall) && r_busy && ((r_wc != '0) || r_inc_pend);

      if (w_sclk_rise) begin
        r_shift  <= w_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_ld_hi)   r_addr_hi <= w_byte;
      if (w_ld_addr) r_ptr     <= w_addr_trunc;
      if (w_write) begin
        r_addr_out <= r_ptr;
        r_data_out <= DATAWIDTH_BUS'(w_byte);
      end
      if (r_inc_pend) begin
        r_ptr <= r_ptr + ADDRESS_WIDTH'(1);
        if (32'(r_wc) < NUM_WEIGHTS) r_wc <= r_wc + ADDRESS_WIDTH'(1);
      end
      if (w_set_err) r_error <= 1'b1;
      if (w_cs_rise) r_busy <= 1'b0;

      // The completed byte stays in r_shift until the next rise, so the
      // falling edge after a boundary can load it straight into MISO.
      if (r_busy && w_byte_done) r_miso_pend <= 1'b1;
      if (r_busy && w_sclk_fall) begin
        if (r_miso_pend) begin
          r_miso_sr   <= r_shift;
          r_miso_pend <= 1'b0;
        end else begin
          r_miso_sr <= {r_miso_sr[6:0], 1'b0};
        end
      end

      if (w_cs_fall) begin
        r_bitcnt    <= '0;
        r_busy      <= 1'b1;
        r_error     <= 1'b0;
        r_wc        <= '0;
        r_miso_sr   <= '0;
        r_miso_pend <= 1'b0;
      end
    end
  end

  assign Loader_MISO_Out         = r_miso_sr[7] & r_busy;
  assign Loader_Addr_Out_DataBUS = r_addr_out;
  assign Loader_Data_Out_DataBUS = r_data_out;
  assign Loader_Load_OutLow      = r_load_n;
  assign Loader_Busy_Out         = r_busy;
  assign Loader_Done_Out         = r_done;
  assign Loader_Error_Out        = r_error;
  assign Loader_WordCount_Out    = r_wc;

endmodule

// File: tb/tb_weight_spi_loader.sv
// Directed frame vectors for weight_spi_loader, with SCLK at clk/8 and a write/done monitor.
module tb_weight_spi_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, load_n, busy, done, err;
  logic [15:0] addr, wc;
  logic [7:0]  data;

  always #5 clk = ~clk;

  weight_spi_loader dut (
    .Loader_Clock_In_Data    (clk),
    .Loader_Reset_InHigh     (rst),
    .Loader_SCLK_In          (sclk),
    .Loader_CSn_In           (csn),
    .Loader_MOSI_In          (mosi),
    .Loader_MISO_Out         (miso),
    .Loader_Addr_Out_DataBUS (addr),
    .Loader_Data_Out_DataBUS (data),
    .Loader_Load_OutLow      (load_n),
    .Loader_Busy_Out         (busy),
    .Loader_Done_Out         (done),
    .Loader_Error_Out        (err),
    .Loader_WordCount_Out    (wc)
  );

  typedef struct packed {
    logic [7:0]       nbytes;
    logic [5:0][7:0]  b;
    logic [3:0]       pbits;
    logic [7:0]       pb;
    logic [7:0]       nwr;
    logic [2:0][15:0] wa;
    logic [2:0][7:0]  wd;
    logic             err;
    logic [7:0]       ndone;
    logic [15:0]      wc;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [23:0] wq[$];
  int unsigned done_cnt = 0;
  int unsigned long_strobes = 0;
  logic        prev_low = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_low = 1'b0;
    end else begin
      if (!load_n) begin
        wq.push_back({addr, data});
        if (prev_low) long_strobes++;
      end
      prev_low = !load_n;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int unsigned nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < int'(nb); i++) begin
      mosi = tx[7-i];
      #40;
      sclk = 1'b1;
      rx[7-i] = miso;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [5:0][7:0] b, input int unsigned n);
    logic [7:0] rx;
    @(negedge clk);
    csn = 1'b0;
    #60;
    for (int k = 0; k < int'(n); k++) spi_bits(b[k], 8, rx);
    #100;
    csn = 1'b1;
    #100;
  endtask

  vec_t        vt[5];
  logic [7:0]  rx;
  int unsigned base_w, base_d, got_w;

  initial begin
    vt[0] = '{nbytes: 8'd6, b: {8'hCC, 8'hBB, 8'hAA, 8'h10, 8'h00, 8'h02}, pbits: 4'd0, pb: 8'h00,
              nwr: 8'd3, wa: {16'h0012, 16'h0011, 16'h0010}, wd: {8'hCC, 8'hBB, 8'hAA},
              err: 1'b0, ndone: 8'd1, wc: 16'd3};
    vt[1] = '{nbytes: 8'd5, b: {8'h00, 8'h22, 8'h11, 8'h00, 8'h00, 8'h03}, pbits: 4'd0, pb: 8'h00,
              nwr: 8'd0, wa: '0, wd: '0, err: 1'b1, ndone: 8'd0, wc: 16'd0};
    vt[2] = '{nbytes: 8'd6, b: {8'h03, 8'h02, 8'h01, 8'hB4, 8'h28, 8'h02}, pbits: 4'd0, pb: 8'h00,
              nwr: 8'd2, wa: {16'h0000, 16'h28B5, 16'h28B4}, wd: {8'h00, 8'h02, 8'h01},
              err: 1'b1, ndone: 8'd1, wc: 16'd2};
    vt[3] = '{nbytes: 8'd4, b: {8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h02}, pbits: 4'd5, pb: 8'hF8,
              nwr: 8'd1, wa: {16'h0000, 16'h0000, 16'h0000}, wd: {8'h00, 8'h00, 8'h5A},
              err: 1'b0, ndone: 8'd1, wc: 16'd1};
    vt[4] = '{nbytes: 8'd4, b: {8'h00, 8'h00, 8'h56, 8'h34, 8'h12, 8'h02}, pbits: 4'd0, pb: 8'h00,
              nwr: 8'd1, wa: {16'h0000, 16'h0000, 16'h1234}, wd: {8'h00, 8'h00, 8'h56},
              err: 1'b0, ndone: 8'd1, wc: 16'd1};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_load_n", load_n, 1);
    check("rst_addr",   addr,   0);
    check("rst_data",   data,   0);
    check("rst_miso",   miso,   0);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_err",    err,    0);
    check("rst_wc",     wc,     0);

    for (int v = 0; v < 5; v++) begin
      base_w = wq.size();
      base_d = done_cnt;
      @(negedge clk);
      csn = 1'b0;
      #60;
      check($sformatf("v%0d_busy_open", v), busy, 1);
      check($sformatf("v%0d_err_clear", v), err, 0);
      for (int k = 0; k < int'(vt[v].nbytes); k++) begin
        spi_bits(vt[v].b[k], 8, rx);
        if (k == 0) check($sformatf("v%0d_miso%0d", v, k), rx, 8'h00);
        else        check($sformatf("v%0d_miso%0d", v, k), rx, vt[v].b[k-1]);
      end
      if (vt[v].pbits != 0) spi_bits(vt[v].pb, vt[v].pbits, rx);
      #100;
      csn = 1'b1;
      #100;
      got_w = wq.size() - base_w;
      check($sformatf("v%0d_nwrites", v), got_w, vt[v].nwr);
      for (int k = 0; k < int'(vt[v].nwr); k++) begin
        if (base_w + k < wq.size()) begin
          check($sformatf("v%0d_waddr%0d", v, k), wq[base_w+k][23:8], vt[v].wa[k]);
          check($sformatf("v%0d_wdata%0d", v, k), wq[base_w+k][7:0], vt[v].wd[k]);
        end
      end
      check($sformatf("v%0d_err", v),   err, vt[v].err);
      check($sformatf("v%0d_done", v),  done_cnt - base_d, vt[v].ndone);
      check($sformatf("v%0d_wc", v),    wc, vt[v].wc);
      check($sformatf("v%0d_busy", v),  busy, 0);
      check($sformatf("v%0d_miso_idle", v), miso, 0);
    end

    // Reset in the middle of a data byte while CSn stays low and SCLK keeps running.
    base_w = wq.size();
    @(negedge clk);
    csn = 1'b0;
    #60;
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h99, 3, rx);
    rst = 1'b1;
    spi_bits(8'h00, 2, rx);
    rst = 1'b0;
    #20;
    check("mrst_load_n", load_n, 1);
    check("mrst_addr",   addr,   0);
    check("mrst_data",   data,   0);
    check("mrst_busy",   busy,   0);
    check("mrst_err",    err,    0);
    check("mrst_wc",     wc,     0);
    check("mrst_miso",   miso,   0);
    spi_bits(8'hE0, 3, rx);
    spi_bits(8'h55, 8, rx);
    #100;
    check("mrst_no_write", wq.size() - base_w, 0);
    check("mrst_idle",     busy, 0);
    csn = 1'b1;
    #100;
    base_d = done_cnt;
    send_frame({8'h00, 8'h00, 8'h77, 8'h01, 8'h00, 8'h02}, 4);
    check("post_rst_nwrites", wq.size() - base_w, 1);
    if (wq.size() > base_w) begin
      check("post_rst_waddr", wq[base_w][23:8], 16'h0001);
      check("post_rst_wdata", wq[base_w][7:0],  8'h77);
    end
    check("post_rst_wc",   wc, 1);
    check("post_rst_done", done_cnt - base_d, 1);
    check("strobe_width",  long_strobes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
